// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, default bit period and sample voting helper
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Bit period minus one; the transmitter uses the same value.
  localparam int unsigned TICK_DEFAULT = 21;

  // Width of the baud counter; TICK never exceeds 511.
  localparam int unsigned CNT_W = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, consumer handshake and status signals of the UART receiver
interface uart_rx_if;

  logic       rx;
  logic       i_ack;
  logic [7:0] o_dat;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  // Line driver / byte consumer side
  modport master (
    output rx,
    output i_ack,
    input  o_dat,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    input  o_busy
  );

  // Receiver side
  modport slave (
    input  rx,
    input  i_ack,
    output o_dat,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    output o_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for an idle-high asynchronous input
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages reset to the idle-high level so reset never fakes a start edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART 8N1 receiver; define UART_RX_MAJORITY_EN for 2-of-3 data/stop bit voting
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned TICK = TICK_DEFAULT
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  uart_rx_if.slave bus
);

  localparam int unsigned       HALF    = (TICK + 1) / 2;
  localparam logic [CNT_W-1:0]  TICK_C  = CNT_W'(TICK);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(HALF - 1);

  logic             rx_s;
  logic             bit_val;
  uart_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       dat_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;

  uart_rx_sync u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .d         (bus.rx),
    .q         (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic samp_a;
  logic samp_b;

  // Capture the two early votes of each bit; the third is the live sample at TICK.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (cnt == TICK_C - CNT_W'(2)) samp_a <= rx_s;
      if (cnt == TICK_C - CNT_W'(1)) samp_b <= rx_s;
    end
  end

  assign bit_val = maj3(samp_a, samp_b, rx_s);
`else
  assign bit_val = rx_s;
`endif

  // Frame FSM: start validation at mid-start-bit, then one sample per bit period.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      dat_q       <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      cnt         <= cnt + CNT_W'(1);

      if (bus.i_ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (cnt == TICK_C) begin
            cnt     <= '0;
            shift   <= {bit_val, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt == TICK_C) begin
            cnt   <= '0;
            state <= IDLE;
            if (bit_val) begin
              // A completing byte overrides a same-cycle ack: it stays valid, no overrun.
              dat_q   <= shift;
              valid_q <= 1'b1;
              if (valid_q && !bus.i_ack) overrun_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.o_dat       = dat_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = frame_err_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;

  localparam int TICK_P = 21;
  localparam int HALF_P = (TICK_P + 1) / 2;
  localparam int BIT_P  = TICK_P + 1;
  localparam int LAT    = BIT_P * 9 + HALF_P + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.TICK(TICK_P)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         done;
    logic [7:0] d;
    logic       good;
  } frame_t;

  typedef struct {
    int s;
    int e;
  } win_t;

  frame_t fq[$];
  win_t   bw[$];

  int   cyc   = 0;
  logic ack_q = 1'b0;

  logic       m_valid = 1'b0;
  logic [7:0] m_dat   = 8'h00;
  logic       m_ovr   = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       prev_v;
  logic       exp_busy;

  int   rise_count = 0;
  int   rise_cyc   = 0;
  int   ferr_count = 0;
  logic v_prev     = 1'b0;
  int   last_first = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    bus.i_ack = 1'b1;
    ticks(1);
    bus.i_ack = 1'b0;
  endtask

  // Edge counter and the ack level each edge actually saw.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    ack_q <= bus.i_ack;
  end

  // Reference model: frame completions land LAT edges after the first edge that sees rx low.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_dat   = 8'h00;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
      fq.delete();
      bw.delete();
    end else begin
      prev_v = m_valid;
      m_ferr = 1'b0;
      if (ack_q) begin
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      if (fq.size() > 0 && fq[0].done == cyc) begin
        if (fq[0].good) begin
          if (prev_v && !ack_q) m_ovr = 1'b1;
          m_valid = 1'b1;
          m_dat   = fq[0].d;
        end else begin
          m_ferr = 1'b1;
        end
        void'(fq.pop_front());
      end
    end
    while (bw.size() > 0 && bw[0].e <= cyc) void'(bw.pop_front());
    exp_busy = 1'b0;
    foreach (bw[i]) if (bw[i].s <= cyc && cyc < bw[i].e) exp_busy = 1'b1;
    check("o_valid",     bus.o_valid,     m_valid);
    check("o_dat",       bus.o_dat,       m_dat);
    check("o_frame_err", bus.o_frame_err, m_ferr);
    check("o_overrun",   bus.o_overrun,   m_ovr);
    check("o_busy",      bus.o_busy,      exp_busy);
  end

  // Event monitor for the directed literal checks.
  initial forever begin
    @(negedge clk);
    if (bus.o_valid === 1'b1 && !v_prev) begin
      rise_count++;
      rise_cyc = cyc;
    end
    if (bus.o_frame_err === 1'b1) ferr_count++;
    v_prev = (bus.o_valid === 1'b1);
  end

  // Serial transmitter; abort_bit >= 0 resets the DUT inside that data bit,
  // glitch_bit >= 0 inverts the line for the one cycle sampled at counter==TICK.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int abort_bit, input int glitch_bit);
    int first;
    first      = cyc + 1;
    last_first = first;
    bw.push_back('{s: first + 2, e: first + LAT});
    if (abort_bit < 0) begin
      fq.push_back('{done: first + LAT, d: d, good: stop_bit});
      // The low stop bit's tail looks like a new start edge and is rejected at mid-bit.
      if (!stop_bit) bw.push_back('{s: first + LAT + 1, e: first + LAT + 1 + HALF_P});
    end
    bus.rx = 1'b0;
    ticks(BIT_P);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      if (i == abort_bit) begin
        ticks(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_dat",   bus.o_dat,   8'h00);
        check("rst_busy",  bus.o_busy,  1'b0);
        check("rst_ovr",   bus.o_overrun, 1'b0);
        bus.rx = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (i == glitch_bit) begin
        ticks(HALF_P);
        bus.rx = ~d[i];
        ticks(1);
        bus.rx = d[i];
        ticks(BIT_P - HALF_P - 1);
      end else begin
        ticks(BIT_P);
      end
    end
    bus.rx = stop_bit;
    ticks(BIT_P);
    bus.rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int base_rise;
    int base_ferr;
    int n;
    bus.rx    = 1'b1;
    bus.i_ack = 1'b0;

    ticks(3);
    check("reset_valid", bus.o_valid, 1'b0);
    check("reset_dat",   bus.o_dat,   8'h00);
    check("reset_busy",  bus.o_busy,  1'b0);
    check("reset_ferr",  bus.o_frame_err, 1'b0);
    rst_n = 1'b1;
    ticks(5);

    // Single frame and its latency from the first edge that sees the start bit.
    send_frame(8'hA5, 1'b1, -1, -1);
    check("a5_latency", rise_cyc - last_first, 211);
    check("a5_dat",     bus.o_dat, 8'hA5);
    check("a5_valid",   bus.o_valid, 1'b1);
    ack_pulse();
    check("a5_ack_clears", bus.o_valid, 1'b0);
    ticks(5);

    // Back-to-back bytes, each acked shortly after it appears.
    base_rise = rise_count;
    base_ferr = ferr_count;
    fork
      begin
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        send_frame(8'h55, 1'b1, -1, -1);
      end
      begin
        repeat (3) begin
          n = 0;
          while (bus.o_valid !== 1'b1 && n < 400) begin
            ticks(1);
            n++;
          end
          if (n >= 400) check("b2b_timeout", 1'b0, 1'b1);
          ticks(1);
          ack_pulse();
        end
      end
    join
    check("b2b_rises",   rise_count - base_rise, 3);
    check("b2b_no_ferr", ferr_count - base_ferr, 0);
    check("b2b_dat",     bus.o_dat, 8'h55);
    ticks(5);

    // Short low glitch on the line is rejected at mid-start-bit.
    base_rise = rise_count;
    bw.push_back('{s: cyc + 3, e: cyc + 3 + HALF_P});
    bus.rx = 1'b0;
    ticks(5);
    bus.rx = 1'b1;
    ticks(40);
    check("glitch_busy",  bus.o_busy, 1'b0);
    check("glitch_rises", rise_count - base_rise, 0);
    check("glitch_ferr",  ferr_count - base_ferr, 0);

    // Frame with a low stop bit: one-cycle error pulse, old byte kept.
    send_frame(8'h3C, 1'b0, -1, -1);
    ticks(30);
    check("ferr_pulses", ferr_count - base_ferr, 1);
    check("ferr_valid",  bus.o_valid, 1'b0);
    check("ferr_dat",    bus.o_dat, 8'h55);

    // Two bytes without ack raise overrun; ack clears both flags.
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    check("ovr_dat",   bus.o_dat, 8'h22);
    check("ovr_valid", bus.o_valid, 1'b1);
    check("ovr_flag",  bus.o_overrun, 1'b1);
    ack_pulse();
    check("ovr_ack_valid", bus.o_valid, 1'b0);
    check("ovr_ack_flag",  bus.o_overrun, 1'b0);
    ticks(5);

    // Ack landing on the completion edge: new byte wins, no overrun.
    send_frame(8'h44, 1'b1, -1, -1);
    fork
      send_frame(8'h66, 1'b1, -1, -1);
      begin
        ticks(LAT);
        bus.i_ack = 1'b1;
        ticks(1);
        bus.i_ack = 1'b0;
      end
    join
    check("coin_dat",   bus.o_dat, 8'h66);
    check("coin_valid", bus.o_valid, 1'b1);
    check("coin_ovr",   bus.o_overrun, 1'b0);

    // Reset inside data bit 4, then a clean frame.
    send_frame(8'h5A, 1'b1, 4, -1);
    ticks(5);
    send_frame(8'h7E, 1'b1, -1, -1);
    check("post_rst_dat",   bus.o_dat, 8'h7E);
    check("post_rst_valid", bus.o_valid, 1'b1);
    ack_pulse();
    ticks(5);

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hC3, 1'b1, -1, 2);
    check("maj_dat",   bus.o_dat, 8'hC3);
    check("maj_valid", bus.o_valid, 1'b1);
    ack_pulse();
    ticks(5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
